// File: rtl/id_exe_stage_reg_pkg.sv
// Shared ARM core definitions: ALU command encodings, shift types,
// field widths and the decoded control bundle used by the ID/EXE register.
package id_exe_stage_reg_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int SHIFT_OP_W = 12;
    localparam int IMM24_W    = 24;
    localparam int STATUS_W   = 4;
    localparam int EXE_CMD_W  = 4;

    // ALU commands (several instructions share one encoding, so no enum)
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_t;

    // Enable bits that must never be active for a bubble
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } ctrl_t;

    // Force every enable to 0 when the slot does not hold a real instruction
    function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic vld);
        return vld ? c : '0;
    endfunction

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// ID->EXE pipeline register bus: decode-side inputs, EXE-side outputs,
// stall/flush controls and debug counters.
interface id_exe_stage_reg_if
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic                  freeze;
    logic                  flush;
    logic                  valid_in;
    logic [DATA_W-1:0]     pc_in;
    logic                  wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in;
    logic [EXE_CMD_W-1:0]  exe_cmd_in;
    logic [DATA_W-1:0]     val_rn_in, val_rm_in;
    logic                  imm_in;
    logic [SHIFT_OP_W-1:0] shift_operand_in;
    logic [IMM24_W-1:0]    signed_imm_24_in;
    logic [REG_ADDR_W-1:0] dest_in, src1_in, src2_in;
    logic [STATUS_W-1:0]   status_in;

    logic                  valid_out;
    logic                  is_mem_out;
    logic [DATA_W-1:0]     pc_out;
    logic                  wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out;
    logic [EXE_CMD_W-1:0]  exe_cmd_out;
    logic [DATA_W-1:0]     val_rn_out, val_rm_out;
    logic                  imm_out;
    logic [SHIFT_OP_W-1:0] shift_operand_out;
    logic [IMM24_W-1:0]    signed_imm_24_out;
    logic [REG_ADDR_W-1:0] dest_out, src1_out, src2_out;
    logic [STATUS_W-1:0]   status_out;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;

    modport master (
        output freeze, flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
               b_in, s_in, exe_cmd_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
        input  valid_out, is_mem_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out,
               b_out, s_out, exe_cmd_out, val_rn_out, val_rm_out, imm_out,
               shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
               status_out, stall_cnt, flush_cnt
    );

    modport slave (
        input  freeze, flush, valid_in, pc_in, wb_en_in, mem_r_en_in, mem_w_en_in,
               b_in, s_in, exe_cmd_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
               signed_imm_24_in, dest_in, src1_in, src2_in, status_in,
        output valid_out, is_mem_out, pc_out, wb_en_out, mem_r_en_out, mem_w_en_out,
               b_out, s_out, exe_cmd_out, val_rn_out, val_rm_out, imm_out,
               shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
               status_out, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/id_exe_stage_reg_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones,
// cleared only by reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: an increment at the ceiling is dropped
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != MAX)) cnt_d = cnt_q + ONE;
    end

    // Counter state, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register of the 5-stage ARM core. Flush beats freeze
// beats load; bubbles always carry zeroed enables so EXE never acts on them.
module id_exe_stage_reg
    import id_exe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic               clk,
    input logic               rst,
    id_exe_stage_reg_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        ctrl_t                 ctrl;
        logic                  is_mem;
        logic [DATA_W-1:0]     pc;
        logic [EXE_CMD_W-1:0]  exe_cmd;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic                  imm;
        logic [SHIFT_OP_W-1:0] shift_operand;
        logic [IMM24_W-1:0]    signed_imm_24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic [STATUS_W-1:0]   status;
    } stage_t;

    stage_t in_w, stage_d, stage_q;
    logic   stall_inc, flush_inc;

    // Gather the decode-side fields; enables are gated by valid_in so a
    // bubble never loads live control bits
    always_comb begin
        in_w               = '0;
        in_w.valid         = bus.valid_in;
        in_w.ctrl          = gate_ctrl('{wb_en:    bus.wb_en_in,
                                         mem_r_en: bus.mem_r_en_in,
                                         mem_w_en: bus.mem_w_en_in,
                                         b:        bus.b_in,
                                         s:        bus.s_in}, bus.valid_in);
        in_w.is_mem        = bus.valid_in & (bus.mem_r_en_in | bus.mem_w_en_in);
        in_w.pc            = bus.pc_in;
        in_w.exe_cmd       = bus.exe_cmd_in;
        in_w.val_rn        = bus.val_rn_in;
        in_w.val_rm        = bus.val_rm_in;
        in_w.imm           = bus.imm_in;
        in_w.shift_operand = bus.shift_operand_in;
        in_w.signed_imm_24 = bus.signed_imm_24_in;
        in_w.dest          = bus.dest_in;
        in_w.src1          = bus.src1_in;
        in_w.src2          = bus.src2_in;
        in_w.status        = bus.status_in;
    end

    // Next stage contents: flush clears everything, freeze holds, else load
    always_comb begin
        stage_d = stage_q;
        if (bus.flush)        stage_d = '0;
        else if (!bus.freeze) stage_d = in_w;
    end

    // Stage register, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stage_q <= '0;
        else      stage_q <= stage_d;
    end

    // A stall is only counted when it actually holds the stage; a flush only
    // when it kills a real instruction (either the resident or the incoming one)
    assign stall_inc = bus.freeze & ~bus.flush;
    assign flush_inc = bus.flush & (stage_q.valid | bus.valid_in);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (bus.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (bus.flush_cnt)
    );

    assign bus.valid_out         = stage_q.valid;
    assign bus.is_mem_out        = stage_q.is_mem;
    assign bus.wb_en_out         = stage_q.ctrl.wb_en;
    assign bus.mem_r_en_out      = stage_q.ctrl.mem_r_en;
    assign bus.mem_w_en_out      = stage_q.ctrl.mem_w_en;
    assign bus.b_out             = stage_q.ctrl.b;
    assign bus.s_out             = stage_q.ctrl.s;
    assign bus.pc_out            = stage_q.pc;
    assign bus.exe_cmd_out       = stage_q.exe_cmd;
    assign bus.val_rn_out        = stage_q.val_rn;
    assign bus.val_rm_out        = stage_q.val_rm;
    assign bus.imm_out           = stage_q.imm;
    assign bus.shift_operand_out = stage_q.shift_operand;
    assign bus.signed_imm_24_out = stage_q.signed_imm_24;
    assign bus.dest_out          = stage_q.dest;
    assign bus.src1_out          = stage_q.src1;
    assign bus.src2_out          = stage_q.src2;
    assign bus.status_out        = stage_q.status;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for the ID/EXE register with a scoreboard of expected
// stage contents pushed at drive time and popped after each edge.
module tb_id_exe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_exe_stage_reg_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    id_exe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic          freeze, flush, valid, wb, mr, mw, b, s;
        logic [DW-1:0] pc;
        logic [3:0]    cmd;
        logic [DW-1:0] rn, rm;
        logic          imm;
        logic [11:0]   sh;
        logic [23:0]   imm24;
        logic [3:0]    dest, src1, src2, status;
    } in_t;

    typedef struct packed {
        logic          valid, wb, mr, mw, b, s, is_mem;
        logic [DW-1:0] pc;
        logic [3:0]    cmd;
        logic [DW-1:0] rn, rm;
        logic          imm;
        logic [11:0]   sh;
        logic [23:0]   imm24;
        logic [3:0]    dest, src1, src2, status;
        logic [CW-1:0] stall, flush;
    } out_t;

    out_t m;
    out_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Reference behaviour of one clock edge
    function automatic out_t nxt(input out_t c, input in_t x);
        out_t n = c;
        if (x.flush) begin
            n       = '0;
            n.stall = c.stall;
            n.flush = (c.valid || x.valid) ? sat_inc(c.flush) : c.flush;
        end else if (x.freeze) begin
            n.stall = sat_inc(c.stall);
        end else begin
            n.valid  = x.valid;
            n.wb     = x.valid & x.wb;
            n.mr     = x.valid & x.mr;
            n.mw     = x.valid & x.mw;
            n.b      = x.valid & x.b;
            n.s      = x.valid & x.s;
            n.is_mem = x.valid & (x.mr | x.mw);
            n.pc     = x.pc;    n.cmd   = x.cmd;   n.rn   = x.rn;   n.rm = x.rm;
            n.imm    = x.imm;   n.sh    = x.sh;    n.imm24 = x.imm24;
            n.dest   = x.dest;  n.src1  = x.src1;  n.src2 = x.src2; n.status = x.status;
        end
        return n;
    endfunction

    function automatic out_t sample();
        out_t s;
        s.valid = bus.valid_out;   s.wb = bus.wb_en_out;     s.mr = bus.mem_r_en_out;
        s.mw    = bus.mem_w_en_out; s.b = bus.b_out;         s.s  = bus.s_out;
        s.is_mem = bus.is_mem_out; s.pc = bus.pc_out;        s.cmd = bus.exe_cmd_out;
        s.rn    = bus.val_rn_out;  s.rm = bus.val_rm_out;    s.imm = bus.imm_out;
        s.sh    = bus.shift_operand_out;  s.imm24 = bus.signed_imm_24_out;
        s.dest  = bus.dest_out;    s.src1 = bus.src1_out;    s.src2 = bus.src2_out;
        s.status = bus.status_out; s.stall = bus.stall_cnt;  s.flush = bus.flush_cnt;
        return s;
    endfunction

    function automatic in_t mk_rand();
        in_t x;
        x        = '0;
        x.valid  = 1'b1;
        {x.wb, x.mr, x.mw, x.b, x.s} = 5'($urandom);
        x.pc     = $urandom;  x.cmd  = 4'($urandom); x.rn = $urandom; x.rm = $urandom;
        x.imm    = 1'($urandom); x.sh = 12'($urandom); x.imm24 = 24'($urandom);
        x.dest   = 4'($urandom); x.src1 = 4'($urandom); x.src2 = 4'($urandom);
        x.status = 4'($urandom);
        return x;
    endfunction

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_bus(input in_t x);
        bus.freeze = x.freeze;  bus.flush = x.flush;  bus.valid_in = x.valid;
        bus.wb_en_in = x.wb;    bus.mem_r_en_in = x.mr; bus.mem_w_en_in = x.mw;
        bus.b_in = x.b;         bus.s_in = x.s;       bus.pc_in = x.pc;
        bus.exe_cmd_in = x.cmd; bus.val_rn_in = x.rn; bus.val_rm_in = x.rm;
        bus.imm_in = x.imm;     bus.shift_operand_in = x.sh;
        bus.signed_imm_24_in = x.imm24;
        bus.dest_in = x.dest;   bus.src1_in = x.src1; bus.src2_in = x.src2;
        bus.status_in = x.status;
    endtask

    // Expect the model's next state after the coming edge, then compare
    task automatic edge_check(input in_t x, input string tag);
        out_t e;
        m = nxt(m, x);
        sb_q.push_back(m);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk(tag, sample(), e);
    endtask

    task automatic step(input in_t x, input string tag);
        @(negedge clk);
        drive_bus(x);
        edge_check(x, tag);
    endtask

    // Async reset pulse between edges with x driven, then the load of x
    task automatic rst_pulse(input in_t x, input string tag);
        @(negedge clk);
        drive_bus(x);
        #1 rst = 1'b0;
        #1 chk({tag, "_clear"}, sample(), '0);
        m = '0;
        #1 rst = 1'b1;
        edge_check(x, {tag, "_after"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        in_t x;
        x = '0;
        drive_bus(x);
        repeat (2) @(posedge clk);
        #1 chk("reset_state", sample(), '0);
        m = '0;
        @(negedge clk) rst = 1'b1;

        x = mk_rand();
        step(x, "load_rand");

        // Reset with every input nonzero
        x = mk_rand();
        {x.wb, x.mr, x.mw, x.b, x.s, x.imm} = '1;
        rst_pulse(x, "async_reset");

        // Plain load of a memory instruction
        x = mk_rand();
        x.mr = 1'b1; x.mw = 1'b0; x.rm = 32'h0000_00F0; x.sh = 12'h104; x.imm = 1'b0;
        step(x, "load_mem");
        chk("load_rm", bus.val_rm_out, 32'hF0);
        chk("load_sh", bus.shift_operand_out, 12'h104);
        chk("load_is_mem", bus.is_mem_out, 1'b1);
        chk("load_valid", bus.valid_out, 1'b1);

        // Freeze while inputs change
        for (int i = 0; i < 3; i++) begin
            x = mk_rand();
            x.freeze = 1'b1;
            step(x, "freeze_hold");
        end
        chk("freeze_rm", bus.val_rm_out, 32'hF0);
        chk("freeze_stall", bus.stall_cnt, 4'd3);

        // Flush wins over freeze
        x = mk_rand();
        x.freeze = 1'b1; x.flush = 1'b1; x.valid = 1'b0;
        step(x, "flush_freeze");
        chk("flush_valid", bus.valid_out, 1'b0);
        chk("flush_wb", bus.wb_en_out, 1'b0);
        chk("flush_is_mem", bus.is_mem_out, 1'b0);
        chk("flush_cnt1", bus.flush_cnt, 4'd1);
        chk("flush_stall", bus.stall_cnt, 4'd3);

        // Bubble with live-looking enables
        x = mk_rand();
        x.valid = 1'b0; x.wb = 1'b1; x.mw = 1'b1;
        step(x, "bubble");
        chk("bubble_valid", bus.valid_out, 1'b0);
        chk("bubble_wb", bus.wb_en_out, 1'b0);
        chk("bubble_mw", bus.mem_w_en_out, 1'b0);
        chk("bubble_is_mem", bus.is_mem_out, 1'b0);

        // Flush of nothing is not counted; flush of an incoming one is
        x = mk_rand();
        x.flush = 1'b1; x.valid = 1'b0;
        step(x, "flush_empty");
        chk("flush_empty_cnt", bus.flush_cnt, 4'd1);
        x = mk_rand();
        x.flush = 1'b1;
        step(x, "flush_incoming");
        chk("flush_incoming_cnt", bus.flush_cnt, 4'd2);

        // Mixed traffic
        for (int i = 0; i < 10; i++) begin
            x = mk_rand();
            x.valid  = 1'($urandom);
            x.freeze = ($urandom_range(0, 3) == 0);
            x.flush  = ($urandom_range(0, 5) == 0);
            step(x, "mixed");
        end

        // Reset in the middle of a freeze, then resume
        x = mk_rand();
        x.freeze = 1'b1;
        rst_pulse(x, "reset_freeze");
        chk("reset_freeze_valid", bus.valid_out, 1'b0);
        x = mk_rand();
        step(x, "resume_load");
        chk("resume_valid", bus.valid_out, 1'b1);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) begin
            x = mk_rand();
            x.freeze = 1'b1;
            step(x, "sat_freeze");
        end
        chk("stall_saturated", bus.stall_cnt, 4'hF);
        x = mk_rand();
        x.freeze = 1'b1;
        step(x, "sat_hold");
        chk("stall_still_saturated", bus.stall_cnt, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
